// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial summator.
//   state_t : controller state encoding (2'd3 is unused and recovers to IDLE)
//   maj3    : three-input majority, the carry function of a full adder
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// One-bit full adder with a carry flop, used as the serial adder stage.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears the carry)
//   clr        : synchronous carry clear, wins over en
//   en         : carry flop captures co on this edge
//   a, b       : operand bits for the current position
//   s, co      : combinational sum and carry-out of a + b + carry
module serial_fa
    import serial_add_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic s,
    output logic co
);

    logic carry;

    assign s  = a ^ b ^ carry;
    assign co = maj3(a, b, carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry <= 1'b0;
        end else if (clr) begin
            carry <= 1'b0;
        end else if (en) begin
            carry <= co;
        end
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequencer for the bit-serial summator. Accepts two reglength-bit
// operands on a valid/ready handshake, adds them LSB-first through
// serial_fa over reglength cycles and holds the (reglength+1)-bit result
// until the consumer takes it.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready high only in IDLE)
//   a, b                 : operands, sampled on the accept edge
//   out_valid / out_ready: result handshake (out_valid high only in DONE)
//   sum                  : a + b, MSB is the final carry
//   busy                 : serial add in progress
// All outputs decode registered state only, so no input reaches an
// output combinationally.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int reglength = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [reglength-1:0] a,
    input  logic [reglength-1:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [reglength:0]   sum,
    output logic                 busy
);

    // Wide enough to reach reglength, so the count never wraps mid-transfer.
    localparam int CNT_W = $clog2(reglength + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(reglength - 1);

    state_t               state;
    state_t               state_nxt;
    logic [reglength-1:0] sa;
    logic [reglength-1:0] sb;
    logic [CNT_W-1:0]     cnt;
    logic [reglength:0]   sum_r;
    logic                 accept;
    logic                 last_bit;
    logic                 fa_s;
    logic                 fa_co;

    assign accept   = in_ready && in_valid;
    assign last_bit = (cnt == LAST);
    assign sum      = sum_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (in_valid)  state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_bit)  state_nxt = ST_DONE;
            ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE:  in_ready  = 1'b1;
            ST_SHIFT: busy      = 1'b1;
            ST_DONE:  out_valid = 1'b1;
            default:  ;
        endcase
    end

    // Operands shift right so bit 0 always feeds the adder; sum bits land
    // at the position counted by cnt, the last carry-out in the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa    <= '0;
            sb    <= '0;
            cnt   <= '0;
            sum_r <= '0;
        end else if (accept) begin
            sa    <= a;
            sb    <= b;
            cnt   <= '0;
            sum_r <= '0;
        end else if (busy) begin
            sum_r[cnt] <= fa_s;
            if (last_bit) begin
                sum_r[reglength] <= fa_co;
            end
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            cnt <= cnt + CNT_W'(1);
        end
    end

    // The carry is cleared on accept so nothing leaks between operations.
    serial_fa u_fa (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (busy),
        .a     (sa[0]),
        .b     (sb[0]),
        .s     (fa_s),
        .co    (fa_co)
    );

endmodule
